coherence_bus_ctrl: RTL and testbench

//  Parametrised coherence bus controller for CPUS cores (previous generation: fixed 2 cores).

---
 rtl/coherence_bus_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - round-robin coherence bus controller: snoop broadcast, MSI cache-to-cache transfer, single RAM port
module coherence_bus_ctrl #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS*WORD_W-1:0] iaddr,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS*WORD_W-1:0] iload,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*WORD_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        cctrans,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS*WORD_W-1:0] dload,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ramwait
);
    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WB     = 3'd1;
    localparam logic [2:0] DRD    = 3'd2;
    localparam logic [2:0] IFETCH = 3'd3;
    localparam logic [2:0] SNOOP  = 3'd4;
    localparam logic [2:0] C2C    = 3'd5;
    localparam logic [2:0] UPG    = 3'd6;

    logic [2:0]       state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] supplier;
    logic [IDX_W-1:0] rr;

    logic [CPUS-1:0]  dreq;
    logic [IDX_W-1:0] pick_d;
    logic [IDX_W-1:0] pick_i;
    logic [IDX_W-1:0] sup_pick;
    logic [IDX_W-1:0] rr_next;
    logic             any_d;
    logic             any_i;
    logic             sup_found;

    logic [WORD_W-1:0] daddr_g;
    logic [WORD_W-1:0] dstore_g;
    logic [WORD_W-1:0] iaddr_g;
    logic [WORD_W-1:0] daddr_s;
    logic [WORD_W-1:0] dstore_s;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        return IDX_W'((int'(base) + off) % CPUS);
    endfunction

    // An S->M upgrade carries only cctrans, so it must count as a dcache request.
    assign dreq    = dREN | dWEN | cctrans;
    assign rr_next = rr_idx(grant, 1);

    assign daddr_g  = daddr[int'(grant)*WORD_W +: WORD_W];
    assign dstore_g = dstore[int'(grant)*WORD_W +: WORD_W];
    assign iaddr_g  = iaddr[int'(grant)*WORD_W +: WORD_W];
    assign daddr_s  = daddr[int'(supplier)*WORD_W +: WORD_W];
    assign dstore_s = dstore[int'(supplier)*WORD_W +: WORD_W];

    always_comb begin
        pick_d    = '0;
        pick_i    = '0;
        any_d     = 1'b0;
        any_i     = 1'b0;
        sup_pick  = '0;
        sup_found = 1'b0;
        for (int i = 0; i < CPUS; i++) begin
            if (!any_d && dreq[rr_idx(rr, i)]) begin
                pick_d = rr_idx(rr, i);
                any_d  = 1'b1;
            end
            if (!any_i && iREN[rr_idx(rr, i)]) begin
                pick_i = rr_idx(rr, i);
                any_i  = 1'b1;
            end
        end
        for (int k = 0; k < CPUS; k++) begin
            if (!sup_found && dWEN[k] && (IDX_W'(k) != grant)) begin
                sup_pick  = IDX_W'(k);
                sup_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            grant    <= '0;
            supplier <= '0;
            rr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_d) begin
                        grant <= pick_d;
                        if (dWEN[pick_d] && !cctrans[pick_d]) state <= WB;
                        else if (cctrans[pick_d])             state <= SNOOP;
                        else                                  state <= DRD;
                    end else if (any_i) begin
                        grant <= pick_i;
                        state <= IFETCH;
                    end
                end
                WB, DRD, IFETCH, C2C: begin
                    if (!ramwait) begin
                        state <= IDLE;
                        rr    <= rr_next;
                    end
                end
                SNOOP: begin
                    if (sup_found) begin
                        supplier <= sup_pick;
                        state    <= C2C;
                    end else if (dREN[grant]) begin
                        state <= DRD;
                    end else begin
                        state <= UPG;
                    end
                end
                UPG: begin
                    state <= IDLE;
                    rr    <= rr_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr_g;
                ramstore = dstore_g;
                if (!ramwait) dwait[grant] = 1'b0;
            end
            DRD: begin
                ramREN  = 1'b1;
                ramaddr = daddr_g;
                if (!ramwait) begin
                    dwait[grant] = 1'b0;
                    dload[int'(grant)*WORD_W +: WORD_W] = ramload;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr_g;
                if (!ramwait) begin
                    iwait[grant] = 1'b0;
                    iload[int'(grant)*WORD_W +: WORD_W] = ramload;
                end
            end
            SNOOP: begin
                ccsnoopaddr = {CPUS{daddr_g}};
                for (int k = 0; k < CPUS; k++) begin
                    if (IDX_W'(k) != grant) begin
                        ccwait[k] = 1'b1;
                        ccinv[k]  = ccwrite[grant];
                    end
                end
            end
            C2C: begin
                ccsnoopaddr = {CPUS{daddr_g}};
                for (int k = 0; k < CPUS; k++) begin
                    if (IDX_W'(k) != grant) ccwait[k] = 1'b1;
                end
                // Supplier's dirty word goes to RAM and to the requester in the same beat.
                ramWEN   = 1'b1;
                ramaddr  = daddr_s;
                ramstore = dstore_s;
                if (!ramwait) begin
                    dwait[grant]    = 1'b0;
                    dwait[supplier] = 1'b0;
                    dload[int'(grant)*WORD_W +: WORD_W] = dstore_s;
                end
            end
            UPG: dwait[grant] = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - scoreboard bench for coherence_bus_ctrl at CPUS=2 and CPUS=4
module tb_coherence_bus_ctrl;
    localparam logic [31:0] MAGIC = 32'h5A5A_0000;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          core;
        logic [31:0] data;
        logic        is_d;
    } exp_t;
    exp_t exp_q[$];

    logic [1:0]  a_iREN, a_iwait, a_dREN, a_dWEN, a_ccwrite, a_cctrans, a_dwait, a_ccwait, a_ccinv;
    logic [63:0] a_iaddr, a_iload, a_daddr, a_dstore, a_dload, a_ccsnoopaddr;
    logic        a_ramREN, a_ramWEN, a_ramwait;
    logic [31:0] a_ramaddr, a_ramstore, a_ramload;

    logic [3:0]   b_iREN, b_iwait, b_dREN, b_dWEN, b_ccwrite, b_cctrans, b_dwait, b_ccwait, b_ccinv;
    logic [127:0] b_iaddr, b_iload, b_daddr, b_dstore, b_dload, b_ccsnoopaddr;
    logic         b_ramREN, b_ramWEN, b_ramwait;
    logic [31:0]  b_ramaddr, b_ramstore, b_ramload;

    coherence_bus_ctrl #(.CPUS(2), .WORD_W(32)) dut_a (
        .CLK(CLK), .nRST(nRST), .iREN(a_iREN), .iaddr(a_iaddr), .iwait(a_iwait), .iload(a_iload),
        .dREN(a_dREN), .dWEN(a_dWEN), .daddr(a_daddr), .dstore(a_dstore), .ccwrite(a_ccwrite),
        .cctrans(a_cctrans), .dwait(a_dwait), .dload(a_dload), .ccwait(a_ccwait), .ccinv(a_ccinv),
        .ccsnoopaddr(a_ccsnoopaddr), .ramREN(a_ramREN), .ramWEN(a_ramWEN), .ramaddr(a_ramaddr),
        .ramstore(a_ramstore), .ramload(a_ramload), .ramwait(a_ramwait)
    );

    coherence_bus_ctrl #(.CPUS(4), .WORD_W(32)) dut_b (
        .CLK(CLK), .nRST(nRST), .iREN(b_iREN), .iaddr(b_iaddr), .iwait(b_iwait), .iload(b_iload),
        .dREN(b_dREN), .dWEN(b_dWEN), .daddr(b_daddr), .dstore(b_dstore), .ccwrite(b_ccwrite),
        .cctrans(b_cctrans), .dwait(b_dwait), .dload(b_dload), .ccwait(b_ccwait), .ccinv(b_ccinv),
        .ccsnoopaddr(b_ccsnoopaddr), .ramREN(b_ramREN), .ramWEN(b_ramWEN), .ramaddr(b_ramaddr),
        .ramstore(b_ramstore), .ramload(b_ramload), .ramwait(b_ramwait)
    );

    task automatic clear_inputs();
        a_iREN = '0; a_iaddr = '0; a_dREN = '0; a_dWEN = '0; a_daddr = '0; a_dstore = '0;
        a_ccwrite = '0; a_cctrans = '0; a_ramload = '0; a_ramwait = 1'b1;
        b_iREN = '0; b_iaddr = '0; b_dREN = '0; b_dWEN = '0; b_daddr = '0; b_dstore = '0;
        b_ccwrite = '0; b_cctrans = '0; b_ramload = '0; b_ramwait = 1'b1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Zero-latency RAM responder for dut_a; returns the first release seen and drops the released requests.
    task automatic run_a(output logic [1:0] rel_d, output logic [63:0] dl, output logic [31:0] waddr,
                         output logic [31:0] wdata, output logic wen, output logic [1:0] cw, output logic to);
        to = 1'b1; rel_d = '0; dl = '0; waddr = '0; wdata = '0; wen = 1'b0; cw = '0;
        for (int c = 0; c < 20 && to; c++) begin
            @(negedge CLK);
            a_ramwait = ~(a_ramREN | a_ramWEN);
            a_ramload = a_ramaddr ^ MAGIC;
            #1;
            if (a_dwait != 2'b11 || a_iwait != 2'b11) begin
                to = 1'b0; rel_d = ~a_dwait; dl = a_dload; waddr = a_ramaddr;
                wdata = a_ramstore; wen = a_ramWEN; cw = a_ccwait;
                a_dREN &= a_dwait; a_dWEN &= a_dwait; a_cctrans &= a_dwait;
                a_ccwrite &= a_dwait; a_iREN &= a_iwait;
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        a_iREN = 2'b01; a_dREN = 2'b10; b_iREN = 4'hF;
        @(negedge CLK); #1;
        n_checks++;
        if ({a_iwait, a_dwait} !== 4'hF) begin n_fail++; $display("FAIL reset_waits_a: got %h required f", {a_iwait, a_dwait}); end
        n_checks++;
        if ({a_ccwait, a_ccinv} !== 4'h0) begin n_fail++; $display("FAIL reset_cc_a: got %h required 0", {a_ccwait, a_ccinv}); end
        n_checks++;
        if ({a_ramREN, a_ramWEN, a_ramaddr, a_ramstore} !== 66'd0) begin n_fail++; $display("FAIL reset_ram_a: got %h required 0", {a_ramREN, a_ramWEN, a_ramaddr, a_ramstore}); end
        n_checks++;
        if ({a_dload, a_iload, a_ccsnoopaddr} !== 192'd0) begin n_fail++; $display("FAIL reset_buses_a: got nonzero bus, required 0"); end
        n_checks++;
        if ({b_iwait, b_dwait, b_ramREN} !== 9'h1FE) begin n_fail++; $display("FAIL reset_b: got %h required 1fe", {b_iwait, b_dwait, b_ramREN}); end
        nRST = 1'b1;
        clear_inputs();
    endtask

    task automatic test_ifetch();
        exp_t e;
        do_reset();
        a_iREN = 2'b01; a_iaddr[31:0] = 32'h40; a_ramwait = 1'b1;
        exp_q.push_back('{core: 0, data: 32'hDEAD, is_d: 1'b0});
        @(negedge CLK); #1;
        n_checks++;
        if ({a_ramREN, a_ramaddr, a_iwait} !== {1'b1, 32'h40, 2'b11}) begin n_fail++; $display("FAIL t1_fetch_start: ren=%b addr=%h iwait=%b required 1/40/11", a_ramREN, a_ramaddr, a_iwait); end
        @(negedge CLK); #1;
        n_checks++;
        if (a_iwait !== 2'b11) begin n_fail++; $display("FAIL t1_wait2: iwait=%b required 11", a_iwait); end
        @(negedge CLK);
        a_ramwait = 1'b0; a_ramload = 32'hDEAD;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (a_iwait !== ~(2'b01 << e.core) || a_iload[e.core*32 +: 32] !== e.data) begin n_fail++; $display("FAIL t1_release: iwait=%b iload=%h required %b/%h", a_iwait, a_iload[31:0], ~(2'b01 << e.core), e.data); end
        a_iREN = 2'b00;
        @(negedge CLK); #1;
        n_checks++;
        if ({a_iwait, a_ramREN} !== 3'b110) begin n_fail++; $display("FAIL t1_idle_after: iwait=%b ren=%b required 11/0", a_iwait, a_ramREN); end
    endtask

    task automatic test_snoop_order();
        exp_t e;
        logic [1:0] rel, cw; logic [63:0] dl; logic [31:0] wa, wd; logic wen, to;
        do_reset();
        a_dREN = 2'b11; a_cctrans = 2'b11; a_daddr = {32'h200, 32'h100};
        exp_q.push_back('{core: 0, data: 32'h100 ^ MAGIC, is_d: 1'b1});
        exp_q.push_back('{core: 1, data: 32'h200 ^ MAGIC, is_d: 1'b1});
        @(negedge CLK); #1;
        n_checks++;
        if ({a_ccwait, a_ccinv, a_ccsnoopaddr} !== {2'b10, 2'b00, 32'h100, 32'h100}) begin n_fail++; $display("FAIL t2_snoop0: ccwait=%b ccinv=%b addr=%h required 10/00/100", a_ccwait, a_ccinv, a_ccsnoopaddr); end
        for (int n = 0; n < 2; n++) begin
            run_a(rel, dl, wa, wd, wen, cw, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || rel !== (2'b01 << e.core) || dl[e.core*32 +: 32] !== e.data) begin n_fail++; $display("FAIL t2_grant%0d: rel=%b data=%h to=%b required rel=%b data=%h", n, rel, dl[e.core*32 +: 32], to, 2'b01 << e.core, e.data); end
        end
        a_dREN = 2'b11; a_cctrans = 2'b00;
        run_a(rel, dl, wa, wd, wen, cw, to);
        n_checks++;
        if (to || rel !== 2'b01) begin n_fail++; $display("FAIL t2_rr_back_to_0: rel=%b to=%b required 01", rel, to); end
        run_a(rel, dl, wa, wd, wen, cw, to);
        n_checks++;
        if (to || rel !== 2'b10 || dl[63:32] !== (32'h200 ^ MAGIC)) begin n_fail++; $display("FAIL t2_back_to_back: rel=%b data=%h required 10/%h", rel, dl[63:32], 32'h200 ^ MAGIC); end
    endtask

    task automatic test_c2c();
        exp_t e;
        logic [1:0] rel, cw; logic [63:0] dl; logic [31:0] wa, wd; logic wen, to;
        do_reset();
        a_dREN = 2'b10; a_cctrans = 2'b10; a_ccwrite = 2'b10; a_daddr[63:32] = 32'h80;
        @(negedge CLK); #1;
        n_checks++;
        if ({a_ccinv, a_ccwait, a_ccsnoopaddr[31:0]} !== {2'b01, 2'b01, 32'h80}) begin n_fail++; $display("FAIL t3_snoop: ccinv=%b ccwait=%b addr=%h required 01/01/80", a_ccinv, a_ccwait, a_ccsnoopaddr[31:0]); end
        a_dWEN = 2'b01; a_daddr[31:0] = 32'h80; a_dstore[31:0] = 32'h1234;
        exp_q.push_back('{core: 1, data: 32'h1234, is_d: 1'b1});
        run_a(rel, dl, wa, wd, wen, cw, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || rel !== 2'b11) begin n_fail++; $display("FAIL t3_release_both: rel=%b to=%b required 11", rel, to); end
        n_checks++;
        if ({wen, wa, wd} !== {1'b1, 32'h80, e.data}) begin n_fail++; $display("FAIL t3_writeback: wen=%b addr=%h data=%h required 1/80/%h", wen, wa, wd, e.data); end
        n_checks++;
        if (dl[e.core*32 +: 32] !== e.data || cw !== 2'b01) begin n_fail++; $display("FAIL t3_dload: dload=%h ccwait=%b required %h/01", dl[e.core*32 +: 32], cw, e.data); end
    endtask

    task automatic test_upgrade();
        do_reset();
        a_cctrans = 2'b01; a_ccwrite = 2'b01;
        @(negedge CLK); #1;
        n_checks++;
        if ({a_ccinv, a_ccwait, a_ramREN, a_ramWEN, a_dwait} !== {2'b10, 2'b10, 1'b0, 1'b0, 2'b11}) begin n_fail++; $display("FAIL t4_snoop: ccinv=%b ccwait=%b ram=%b%b dwait=%b required 10/10/00/11", a_ccinv, a_ccwait, a_ramREN, a_ramWEN, a_dwait); end
        @(negedge CLK); #1;
        n_checks++;
        if ({a_ccinv, a_ramREN, a_ramWEN, a_dwait} !== {2'b00, 1'b0, 1'b0, 2'b10}) begin n_fail++; $display("FAIL t4_release: ccinv=%b ram=%b%b dwait=%b required 00/00/10", a_ccinv, a_ramREN, a_ramWEN, a_dwait); end
        a_cctrans = 2'b00; a_ccwrite = 2'b00;
        @(negedge CLK); #1;
        n_checks++;
        if (a_dwait !== 2'b11) begin n_fail++; $display("FAIL t4_one_cycle: dwait=%b required 11", a_dwait); end
    endtask

    task automatic test_rr_four();
        exp_t e;
        logic [3:0] want;
        int grants = 0;
        int cyc = 0;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        b_iREN = 4'hF;
        for (int k = 0; k < 4; k++) b_iaddr[k*32 +: 32] = 32'h1000 + 32'(k * 4);
        foreach (order[j]) exp_q.push_back('{core: order[j], data: (32'h1000 + 32'(order[j] * 4)) ^ MAGIC, is_d: 1'b0});
        while (exp_q.size() > 0 && cyc < 80) begin
            cyc++;
            @(negedge CLK);
            b_ramwait = ~(b_ramREN | b_ramWEN);
            b_ramload = b_ramaddr ^ MAGIC;
            #1;
            if (b_iwait != 4'hF || b_dwait != 4'hF) begin
                e = exp_q.pop_front();
                want = ~(4'b0001 << e.core);
                n_checks++;
                if (e.is_d) begin
                    if ({b_dwait, b_iwait, b_ramWEN, b_ramaddr, b_ramstore} !== {want, 4'hF, 1'b1, 32'h2000, e.data}) begin n_fail++; $display("FAIL t5_dwb_core%0d: dwait=%b iwait=%b addr=%h data=%h required %b/1111/2000/%h", e.core, b_dwait, b_iwait, b_ramaddr, b_ramstore, want, e.data); end
                    b_dWEN = 4'b0000;
                end else begin
                    if ({b_iwait, b_dwait, b_iload[e.core*32 +: 32]} !== {want, 4'hF, e.data}) begin n_fail++; $display("FAIL t5_grant%0d: iwait=%b dwait=%b required iwait=%b data=%h", grants, b_iwait, b_dwait, want, e.data); end
                end
                grants++;
                if (grants == 5) begin
                    b_dWEN = 4'b0100; b_daddr[95:64] = 32'h2000; b_dstore[95:64] = 32'hBEEF;
                    exp_q.push_back('{core: 2, data: 32'hBEEF, is_d: 1'b1});
                    exp_q.push_back('{core: 3, data: 32'h100C ^ MAGIC, is_d: 1'b0});
                    exp_q.push_back('{core: 0, data: 32'h1000 ^ MAGIC, is_d: 1'b0});
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL t5_timeout: %0d releases outstanding, required 0", exp_q.size()); end
        exp_q.delete();
        b_iREN = 4'h0;
    endtask

    task automatic test_reset_mid_c2c();
        exp_t e;
        logic [1:0] rel, cw; logic [63:0] dl; logic [31:0] wa, wd; logic wen, to;
        do_reset();
        a_dREN = 2'b10; a_cctrans = 2'b10; a_ccwrite = 2'b10; a_daddr[63:32] = 32'h80;
        @(negedge CLK);
        a_dWEN = 2'b01; a_daddr[31:0] = 32'h80; a_dstore[31:0] = 32'h5678; a_ramwait = 1'b1;
        @(negedge CLK); #1;
        n_checks++;
        if ({a_ramWEN, a_ccwait, a_dwait} !== {1'b1, 2'b01, 2'b11}) begin n_fail++; $display("FAIL t6_in_c2c: wen=%b ccwait=%b dwait=%b required 1/01/11", a_ramWEN, a_ccwait, a_dwait); end
        #1 nRST = 1'b0;
        #1;
        n_checks++;
        if ({a_ramWEN, a_ramREN, a_iwait, a_dwait, a_ccwait, a_ccinv} !== {1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00}) begin n_fail++; $display("FAIL t6_async_reset: wen=%b ren=%b iwait=%b dwait=%b ccwait=%b required 0/0/11/11/00", a_ramWEN, a_ramREN, a_iwait, a_dwait, a_ccwait); end
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;
        a_dREN = 2'b01; a_daddr[31:0] = 32'h300;
        exp_q.push_back('{core: 0, data: 32'h300 ^ MAGIC, is_d: 1'b1});
        run_a(rel, dl, wa, wd, wen, cw, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || rel !== 2'b01 || dl[e.core*32 +: 32] !== e.data) begin n_fail++; $display("FAIL t6_restart: rel=%b data=%h to=%b required 01/%h", rel, dl[31:0], to, e.data); end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_snoop_order();
        test_c2c();
        test_upgrade();
        test_rr_four();
        test_reset_mid_c2c();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
